// File: rtl/ghost_move_scheduler.sv
// Round-robin ghost stepper: commits in-bound ghost moves once per move tick, resolves
// Pac-Man collisions and runs the scatter/chase/frightened mode timer.
module ghost_move_scheduler #(
  parameter int unsigned GHOSTS        = 4,
  parameter int unsigned TICK_CYCLES   = 2500000,
  parameter int unsigned SCATTER_TICKS = 35,
  parameter int unsigned CHASE_TICKS   = 100,
  parameter int unsigned FRIGHT_TICKS  = 30,
  parameter int unsigned WIDTH         = 640,
  parameter int unsigned HEIGHT        = 480,
  parameter int unsigned XW            = $clog2(WIDTH),
  parameter int unsigned YW            = $clog2(HEIGHT),
  parameter logic [GHOSTS*XW-1:0] SPAWN_X = {10'd340, 10'd320, 10'd300, 10'd20},
  parameter logic [GHOSTS*YW-1:0] SPAWN_Y = {9'd220, 9'd220, 9'd220, 9'd320},
  parameter int unsigned BOUND_X1      = 620,
  parameter int unsigned BOUND_Y1      = 460
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 power_pellet,
  input  logic [XW-1:0]        pac_x,
  input  logic [YW-1:0]        pac_y,
  input  logic [GHOSTS*XW-1:0] ghost_next_x,
  input  logic [GHOSTS*YW-1:0] ghost_next_y,
  output logic [GHOSTS-1:0]    ghost_step,
  output logic [GHOSTS*XW-1:0] ghost_x,
  output logic [GHOSTS*YW-1:0] ghost_y,
  output logic [1:0]           mode,
  output logic [GHOSTS-1:0]    ghost_eaten,
  output logic                 game_over,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TCW = $clog2(TICK_CYCLES);
  localparam int unsigned CW  = $clog2((SCATTER_TICKS > CHASE_TICKS ?
                                        SCATTER_TICKS : CHASE_TICKS) + 1);
  localparam int unsigned FW  = $clog2(FRIGHT_TICKS + 1);

  typedef enum logic [2:0] {StIdle, StStep, StWait, StCommit, StCheck} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [TCW-1:0]         tick_cnt_q;
  logic                   tick;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   game_over_q, game_over_d;
  logic [GHOSTS*XW-1:0]   gx_q, gx_d;
  logic [GHOSTS*YW-1:0]   gy_q, gy_d;
  logic [1:0]             mode_q, mode_d, saved_q, saved_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [GHOSTS-1:0]      eaten_q, eaten_d;
  logic [XW-1:0]          sel_x;
  logic [YW-1:0]          sel_y;
  logic                   fright_now;

  assign tick = run && !game_over_q && (tick_cnt_q == TCW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else if (run && !game_over_q) begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  assign sel_x      = ghost_next_x[idx_q*XW +: XW];
  assign sel_y      = ghost_next_y[idx_q*YW +: YW];
  // A pellet landing in the check cycle already counts for the collision.
  assign fright_now = (mode_q == 2'd2) || power_pellet;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    game_over_d = game_over_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    mode_d      = mode_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    eaten_d     = '0;
    ghost_step  = '0;

    if (tick && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (run && !game_over_q && (tick || pending_q)) begin
          state_d   = StStep;
          idx_d     = '0;
          pending_d = tick && pending_q;
        end
      end
      StStep: begin
        ghost_step[idx_q] = 1'b1;
        state_d           = StWait;
      end
      StWait: state_d = StCommit;
      StCommit: begin
        if ((sel_x <= XW'(BOUND_X1)) && (sel_y <= YW'(BOUND_Y1))) begin
          gx_d[idx_q*XW +: XW] = sel_x;
          gy_d[idx_q*YW +: YW] = sel_y;
        end
        if (idx_q == 2'(GHOSTS - 1)) begin
          state_d = StCheck;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StStep;
        end
      end
      StCheck: begin
        for (int i = 0; i < GHOSTS; i++) begin
          if ((gx_q[i*XW +: XW] == pac_x) && (gy_q[i*YW +: YW] == pac_y)) begin
            if (fright_now) begin
              eaten_d[i]       = 1'b1;
              gx_d[i*XW +: XW] = SPAWN_X[i*XW +: XW];
              gy_d[i*YW +: YW] = SPAWN_Y[i*YW +: YW];
            end else begin
              game_over_d = 1'b1;
            end
          end
        end
        case (mode_q)
          2'd0: begin
            if (cnt_q == CW'(SCATTER_TICKS - 1)) begin
              mode_d = 2'd1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          2'd1: begin
            if (cnt_q == CW'(CHASE_TICKS - 1)) begin
              mode_d = 2'd0;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          2'd2: begin
            if (fcnt_q <= FW'(1)) begin
              fcnt_d = '0;
              mode_d = saved_q;
            end else begin
              fcnt_d = fcnt_q - 1'b1;
            end
          end
          default: mode_d = 2'd0;
        endcase
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A pellet overrides any timer advance made in the same cycle.
    if (power_pellet) begin
      if (mode_q != 2'd2) saved_d = mode_q;
      mode_d = 2'd2;
      cnt_d  = cnt_q;
      fcnt_d = FW'(FRIGHT_TICKS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      game_over_q <= 1'b0;
      gx_q        <= SPAWN_X;
      gy_q        <= SPAWN_Y;
      mode_q      <= 2'd0;
      saved_q     <= 2'd0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      eaten_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      game_over_q <= game_over_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      mode_q      <= mode_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      eaten_q     <= eaten_d;
    end
  end

  assign ghost_x     = gx_q;
  assign ghost_y     = gy_q;
  assign mode        = mode_q;
  assign ghost_eaten = eaten_q;
  assign game_over   = game_over_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench for ghost_move_scheduler with a reference model feeding a scoreboard queue.
module tb_ghost_move_scheduler;

  localparam int SCAT = 2;
  localparam int CHASE = 3;
  localparam int FRIGHT = 2;
  localparam int SPX[4] = '{20, 300, 320, 340};
  localparam int SPY[4] = '{320, 220, 220, 220};

  typedef struct packed {
    logic [39:0] x;
    logic [35:0] y;
    logic [1:0]  mode;
    logic [3:0]  eaten;
    logic        go;
    logic        ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        power_pellet;
  logic [9:0]  pac_x;
  logic [8:0]  pac_y;
  logic [39:0] ghost_next_x;
  logic [35:0] ghost_next_y;
  logic [3:0]  ghost_step;
  logic [39:0] ghost_x;
  logic [35:0] ghost_y;
  logic [1:0]  mode;
  logic [3:0]  ghost_eaten;
  logic        game_over;
  logic        overrun;
  logic        busy;

  logic [9:0]  nx[4];
  logic [8:0]  ny[4];
  logic [9:0]  m_x[4];
  logic [8:0]  m_y[4];
  int          m_mode, m_cnt, m_fcnt, m_saved;
  logic        m_go, m_ovr;
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  tc_last = 4'd15;

  ghost_move_scheduler #(
    .TICK_CYCLES  (16),
    .SCATTER_TICKS(SCAT),
    .CHASE_TICKS  (CHASE),
    .FRIGHT_TICKS (FRIGHT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .power_pellet(power_pellet),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .ghost_next_x(ghost_next_x),
    .ghost_next_y(ghost_next_y),
    .ghost_step  (ghost_step),
    .ghost_x     (ghost_x),
    .ghost_y     (ghost_y),
    .mode        (mode),
    .ghost_eaten (ghost_eaten),
    .game_over   (game_over),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    ghost_next_x = '0;
    ghost_next_y = '0;
    for (int i = 0; i < 4; i++) begin
      ghost_next_x[i*10 +: 10] = nx[i];
      ghost_next_y[i*9 +: 9]   = ny[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 10'(SPX[i]);
      m_y[i] = 9'(SPY[i]);
    end
    m_mode = 0; m_cnt = 0; m_fcnt = 0; m_saved = 0;
    m_go = 1'b0; m_ovr = 1'b0;
    sb.delete();
  endtask

  function automatic logic [39:0] pack_x();
    logic [39:0] v;
    for (int i = 0; i < 4; i++) v[i*10 +: 10] = m_x[i];
    return v;
  endfunction

  function automatic logic [35:0] pack_y();
    logic [35:0] v;
    for (int i = 0; i < 4; i++) v[i*9 +: 9] = m_y[i];
    return v;
  endfunction

  // Predict the state after one serviced tick and queue it.
  task automatic model_tick();
    exp_t e;
    e.eaten = '0;
    for (int i = 0; i < 4; i++) begin
      if (nx[i] <= 10'd620 && ny[i] <= 9'd460) begin
        m_x[i] = nx[i];
        m_y[i] = ny[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (m_x[i] == pac_x && m_y[i] == pac_y) begin
        if (m_mode == 2) begin
          e.eaten[i] = 1'b1;
          m_x[i] = 10'(SPX[i]);
          m_y[i] = 9'(SPY[i]);
        end else begin
          m_go = 1'b1;
        end
      end
    end
    if (m_mode == 0) begin
      if (m_cnt == SCAT - 1) begin m_mode = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (m_mode == 1) begin
      if (m_cnt == CHASE - 1) begin m_mode = 0; m_cnt = 0; end
      else m_cnt++;
    end else begin
      m_fcnt--;
      if (m_fcnt == 0) m_mode = m_saved;
    end
    e.x = pack_x();
    e.y = pack_y();
    e.mode = 2'(m_mode);
    e.go = m_go;
    e.ovr = m_ovr;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("ghost_x", 64'(ghost_x), 64'(e.x));
      chk("ghost_y", 64'(ghost_y), 64'(e.y));
      chk("mode", 64'(mode), 64'(e.mode));
      chk("ghost_eaten", 64'(ghost_eaten), 64'(e.eaten));
      chk("game_over", 64'(game_over), 64'(e.go));
      chk("overrun", 64'(overrun), 64'(e.ovr));
    end
  endtask

  // Follow one sequence from IDLE: step order, busy length, then scoreboard compare.
  task automatic do_tick(output int wait_cyc);
    int n;
    int b;
    logic [3:0] st[4];
    for (int k = 0; k < 4; k++) st[k] = 'x;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    wait_cyc = n;
    chk("seq_start", 64'(busy), 64'(1));
    b = 0;
    while (busy && b < 40) begin
      if (b % 3 == 0 && b < 12) st[b/3] = ghost_step;
      b++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(b), 64'(13));
    for (int k = 0; k < 4; k++) chk("ghost_step", 64'(st[k]), 64'(1 << k));
    sb_check();
  endtask

  initial begin
    int w;
    int n;
    reset = 1'b0;
    run = 1'b0;
    power_pellet = 1'b0;
    pac_x = 10'd600;
    pac_y = 9'd400;
    for (int i = 0; i < 4; i++) begin
      nx[i] = 10'(SPX[i]);
      ny[i] = 9'(SPY[i]);
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ghost_x", 64'(ghost_x), 64'(pack_x()));
    chk("rst_ghost_y", 64'(ghost_y), 64'(pack_y()));
    chk("rst_mode", 64'(mode), 64'(0));
    chk("rst_ghost_step", 64'(ghost_step), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_flags", 64'({game_over, overrun, ghost_eaten}), 64'(0));
    reset = 1'b1;

    // Ghost 2 moves in bounds, ghost 1 tries to leave the maze.
    nx[2] = 10'd360;
    nx[1] = 10'd640;
    run = 1'b1;
    for (int t = 0; t < 3; t++) begin
      model_tick();
      do_tick(w);
    end

    // Chase with one tick done: power pellet enters frightened.
    power_pellet = 1'b1;
    @(negedge clk);
    power_pellet = 1'b0;
    m_saved = m_mode;
    m_mode = 2;
    m_fcnt = FRIGHT;
    chk("mode_after_pellet", 64'(mode), 64'(2));
    nx[3] = 10'd350;
    pac_x = 10'd350;
    pac_y = 9'd220;
    model_tick();
    do_tick(w);
    @(negedge clk);
    chk("ghost_eaten_pulse_end", 64'(ghost_eaten), 64'(0));
    pac_x = 10'd600;
    pac_y = 9'd400;
    for (int t = 0; t < 3; t++) begin
      model_tick();
      do_tick(w);
    end

    // Force extra ticks inside one busy window.
    m_ovr = 1'b1;
    model_tick();
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    force dut.tick_cnt_q = tc_last;
    repeat (2) @(negedge clk);
    release dut.tick_cnt_q;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("overrun_seq_end", 64'(busy), 64'(0));
    sb_check();
    model_tick();
    do_tick(w);
    chk("pending_start_delay", 64'(w), 64'(1));

    // Asynchronous reset, then a chase-mode catch ends the game.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_overrun", 64'(overrun), 64'(0));
    chk("mid_rst_ghost_x", 64'(ghost_x), 64'({10'd340, 10'd320, 10'd300, 10'd20}));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nx[i] = 10'(SPX[i]);
      ny[i] = 9'(SPY[i]);
    end
    model_reset();
    pac_x = 10'd340;
    pac_y = 9'd220;
    model_tick();
    do_tick(w);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("game_over_freeze", 64'(n), 64'(0));
    chk("game_over_sticky", 64'(game_over), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: observed timeout expected completion");
  end

endmodule
